// File: rtl/clock_time_setter_if.sv
// Keypad key-event bus between the keypad decoder and the time setter.
//   key_valid : one-cycle strobe per decoded key press
//   key_code  : decoded key (0-9 digits, 10..15 = A, B, C, D, *, #)
// master = keypad decoder (drives), slave = clock_time_setter (receives).
interface clock_time_setter_if;
    logic       key_valid;
    logic [3:0] key_code;

    modport master (output key_valid, output key_code);
    modport slave  (input  key_valid, input  key_code);
endinterface

// File: rtl/clock_time_setter.sv
// Keypad-driven setting controller for the clock time and NUM_ALARMS alarm
// slots. Digits are staged in a 4-nibble buffer, validated against 24-hour
// limits, and committed only when the fourth digit is accepted.
// Ports:
//   clk, rstn      : clock, asynchronous active-low reset
//   key            : keypad event bus (slave side)
//   set_hour/minute: committed time (BCD), time_load pulses on commit
//   alarm_hour/min : packed alarm times, slot k at [8k+7:8k] (BCD)
//   alarm_en       : per-alarm enable, alarm_sel : selected alarm index
//   mode           : 0 idle, 1 edit time, 2 edit alarm
//   digit_idx      : next digit position in edit mode (0 in idle)
//   key_err        : one-cycle pulse when a digit is rejected
module clock_time_setter #(
    parameter int NUM_ALARMS     = 2,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                    clk,
    input  logic                    rstn,
    clock_time_setter_if.slave      key,
    output logic [7:0]              set_hour,
    output logic [7:0]              set_minute,
    output logic                    time_load,
    output logic [8*NUM_ALARMS-1:0] alarm_hour,
    output logic [8*NUM_ALARMS-1:0] alarm_minute,
    output logic [NUM_ALARMS-1:0]   alarm_en,
    output logic [3:0]              alarm_sel,
    output logic [1:0]              mode,
    output logic [1:0]              digit_idx,
    output logic                    key_err
);
    localparam int             AW            = 8 * NUM_ALARMS;
    localparam int             TW            = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]  TMO_LAST      = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [AW-1:0]  ALARM_MIN_RST = AW'(8'h01);
    localparam logic [3:0]     SEL_LAST      = 4'(NUM_ALARMS - 1);

    localparam logic [3:0] KEY_9      = 4'd9;
    localparam logic [3:0] KEY_TIME   = 4'd10;
    localparam logic [3:0] KEY_ALARM  = 4'd11;
    localparam logic [3:0] KEY_NEXT   = 4'd12;
    localparam logic [3:0] KEY_TOGGLE = 4'd13;
    localparam logic [3:0] KEY_CANCEL = 4'd14;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TIME  = 2'd1,
        ST_ALARM = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      digit_idx_q, digit_idx_d;
    logic [15:0]     buf_q, buf_d;        // d0 at [15:12] ... d3 at [3:0]
    logic [3:0]      target_q, target_d;  // alarm slot latched on edit entry
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [7:0]      set_hour_q, set_hour_d, set_minute_q, set_minute_d;
    logic            time_load_q, time_load_d, key_err_q, key_err_d;
    logic [AW-1:0]   alarm_hour_q, alarm_hour_d, alarm_minute_q, alarm_minute_d;
    logic [NUM_ALARMS-1:0] alarm_en_q, alarm_en_d;
    logic [3:0]      alarm_sel_q, alarm_sel_d;

    logic in_edit_s, is_digit_s, digit_ok_s, accept_s, reject_s, commit_s, abort_s;
    logic idle_key_s;

    // Key decode and 24-hour digit validation for the current position.
    always_comb begin
        is_digit_s = (key.key_code <= KEY_9);
        case (digit_idx_q)
            2'd0: digit_ok_s = (key.key_code <= 4'd2);
            2'd1: begin
                if (buf_q[15:12] == 4'd2) begin
                    digit_ok_s = (key.key_code <= 4'd3);
                end else begin
                    digit_ok_s = (key.key_code <= 4'd9);
                end
            end
            2'd2:    digit_ok_s = (key.key_code <= 4'd5);
            2'd3:    digit_ok_s = (key.key_code <= 4'd9);
            default: digit_ok_s = 1'b0;
        endcase
    end

    assign in_edit_s  = (state_q != ST_IDLE);
    assign idle_key_s = key.key_valid && !in_edit_s;
    assign accept_s   = in_edit_s && key.key_valid && is_digit_s && digit_ok_s;
    assign reject_s   = in_edit_s && key.key_valid && is_digit_s && !digit_ok_s;
    assign commit_s   = accept_s && (digit_idx_q == 2'd3);
    // Cancel and timeout share one abort path; a key in the expiring cycle
    // resets the counter instead of aborting.
    assign abort_s    = in_edit_s &&
                        ((key.key_valid && (key.key_code == KEY_CANCEL)) ||
                         (!key.key_valid && (tmo_q == TMO_LAST)));

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (idle_key_s && (key.key_code == KEY_TIME)) begin
                    state_d = ST_TIME;
                end else if (idle_key_s && (key.key_code == KEY_ALARM)) begin
                    state_d = ST_ALARM;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_TIME, ST_ALARM: begin
                if (commit_s || abort_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output / datapath next values (registered below).
    always_comb begin
        buf_d          = buf_q;
        target_d       = target_q;
        set_hour_d     = set_hour_q;
        set_minute_d   = set_minute_q;
        alarm_hour_d   = alarm_hour_q;
        alarm_minute_d = alarm_minute_q;
        alarm_en_d     = alarm_en_q;
        alarm_sel_d    = alarm_sel_q;
        time_load_d    = commit_s && (state_q == ST_TIME);
        key_err_d      = reject_s;

        if (state_d == ST_IDLE) begin
            digit_idx_d = 2'd0;
        end else if (accept_s) begin
            digit_idx_d = digit_idx_q + 2'd1;
        end else begin
            digit_idx_d = digit_idx_q;
        end

        if (!in_edit_s || key.key_valid || (state_d == ST_IDLE)) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end

        // Buffer is discarded whenever the machine is idle.
        if (!in_edit_s) begin
            buf_d = 16'h0000;
        end else if (accept_s) begin
            case (digit_idx_q)
                2'd0:    buf_d[15:12] = key.key_code;
                2'd1:    buf_d[11:8]  = key.key_code;
                2'd2:    buf_d[7:4]   = key.key_code;
                2'd3:    buf_d[3:0]   = key.key_code;
                default: buf_d        = buf_q;
            endcase
        end else begin
            buf_d = buf_q;
        end

        if (idle_key_s && (key.key_code == KEY_ALARM)) begin
            target_d = alarm_sel_q;
        end else begin
            target_d = target_q;
        end

        if (idle_key_s && (key.key_code == KEY_NEXT)) begin
            if (alarm_sel_q >= SEL_LAST) begin
                alarm_sel_d = 4'd0;
            end else begin
                alarm_sel_d = alarm_sel_q + 4'd1;
            end
        end else begin
            alarm_sel_d = alarm_sel_q;
        end

        if (commit_s && (state_q == ST_TIME)) begin
            set_hour_d   = buf_q[15:8];
            set_minute_d = {buf_q[7:4], key.key_code};
        end else begin
            set_hour_d   = set_hour_q;
            set_minute_d = set_minute_q;
        end

        for (int k = 0; k < NUM_ALARMS; k++) begin
            if (commit_s && (state_q == ST_ALARM) && (target_q == 4'(k))) begin
                alarm_hour_d[8*k +: 8]   = buf_q[15:8];
                alarm_minute_d[8*k +: 8] = {buf_q[7:4], key.key_code};
                alarm_en_d[k]            = 1'b1;
            end else if (idle_key_s && (key.key_code == KEY_TOGGLE) &&
                         (alarm_sel_q == 4'(k))) begin
                alarm_en_d[k] = ~alarm_en_q[k];
            end else begin
                alarm_en_d[k] = alarm_en_q[k];
            end
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            digit_idx_q    <= 2'd0;
            buf_q          <= 16'h0000;
            target_q       <= 4'd0;
            tmo_q          <= '0;
            set_hour_q     <= 8'h00;
            set_minute_q   <= 8'h00;
            time_load_q    <= 1'b0;
            key_err_q      <= 1'b0;
            alarm_hour_q   <= '0;
            alarm_minute_q <= ALARM_MIN_RST;
            alarm_en_q     <= '0;
            alarm_sel_q    <= 4'd0;
        end else begin
            digit_idx_q    <= digit_idx_d;
            buf_q          <= buf_d;
            target_q       <= target_d;
            tmo_q          <= tmo_d;
            set_hour_q     <= set_hour_d;
            set_minute_q   <= set_minute_d;
            time_load_q    <= time_load_d;
            key_err_q      <= key_err_d;
            alarm_hour_q   <= alarm_hour_d;
            alarm_minute_q <= alarm_minute_d;
            alarm_en_q     <= alarm_en_d;
            alarm_sel_q    <= alarm_sel_d;
        end
    end

    assign set_hour     = set_hour_q;
    assign set_minute   = set_minute_q;
    assign time_load    = time_load_q;
    assign alarm_hour   = alarm_hour_q;
    assign alarm_minute = alarm_minute_q;
    assign alarm_en     = alarm_en_q;
    assign alarm_sel    = alarm_sel_q;
    assign mode         = state_q;
    assign digit_idx    = digit_idx_q;
    assign key_err      = key_err_q;
endmodule

// File: tb/tb_clock_time_setter.sv
// Directed bench for clock_time_setter with NUM_ALARMS=2, TIMEOUT_CYCLES=8.
module tb_clock_time_setter;
    logic        clk;
    logic        rstn;
    logic [7:0]  set_hour, set_minute;
    logic        time_load, key_err;
    logic [15:0] alarm_hour, alarm_minute;
    logic [1:0]  alarm_en;
    logic [3:0]  alarm_sel;
    logic [1:0]  mode, digit_idx;
    int          errors;
    int          checks;

    clock_time_setter_if kif ();

    clock_time_setter #(.NUM_ALARMS(2), .TIMEOUT_CYCLES(8)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .key          (kif.slave),
        .set_hour     (set_hour),
        .set_minute   (set_minute),
        .time_load    (time_load),
        .alarm_hour   (alarm_hour),
        .alarm_minute (alarm_minute),
        .alarm_en     (alarm_en),
        .alarm_sel    (alarm_sel),
        .mode         (mode),
        .digit_idx    (digit_idx),
        .key_err      (key_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called 1 time unit after a rising edge; key is captured by the next edge.
    task automatic press(input logic [3:0] code);
        kif.key_valid = 1'b1;
        kif.key_code  = code;
        @(posedge clk);
        #1;
        kif.key_valid = 1'b0;
        kif.key_code  = 4'd15;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_hour"},  32'(set_hour),     32'h00);
        chk({tag, "_min"},   32'(set_minute),   32'h00);
        chk({tag, "_load"},  32'(time_load),    32'h0);
        chk({tag, "_err"},   32'(key_err),      32'h0);
        chk({tag, "_ahour"}, 32'(alarm_hour),   32'h0000);
        chk({tag, "_amin"},  32'(alarm_minute), 32'h0001);
        chk({tag, "_aen"},   32'(alarm_en),     32'h0);
        chk({tag, "_asel"},  32'(alarm_sel),    32'h0);
        chk({tag, "_mode"},  32'(mode),         32'h0);
        chk({tag, "_idx"},   32'(digit_idx),    32'h0);
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        rstn          = 1'b0;
        kif.key_valid = 1'b0;
        kif.key_code  = 4'd0;
        #12;
        chk_reset("rst");
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back time entry 12:34.
        press(4'd10);
        chk("a_mode", 32'(mode), 32'h1);
        chk("a_idx", 32'(digit_idx), 32'h0);
        press(4'd1); press(4'd2); press(4'd3);
        chk("t3_idx", 32'(digit_idx), 32'h3);
        chk("t3_hold", 32'(set_hour), 32'h00);
        press(4'd4);
        chk("t_hour", 32'(set_hour), 32'h12);
        chk("t_min", 32'(set_minute), 32'h34);
        chk("t_load", 32'(time_load), 32'h1);
        chk("t_mode", 32'(mode), 32'h0);
        idle(1);
        chk("t_load_off", 32'(time_load), 32'h0);

        // Validation: 24 rejected, 36 rejected, commit 23:59.
        press(4'd10); press(4'd2); press(4'd4);
        chk("v4_err", 32'(key_err), 32'h1);
        chk("v4_idx", 32'(digit_idx), 32'h1);
        press(4'd3);
        chk("v3_err", 32'(key_err), 32'h0);
        chk("v3_idx", 32'(digit_idx), 32'h2);
        press(4'd6);
        chk("v6_err", 32'(key_err), 32'h1);
        chk("v6_idx", 32'(digit_idx), 32'h2);
        press(4'd15);
        chk("vh_err", 32'(key_err), 32'h0);
        chk("vh_mode", 32'(mode), 32'h1);
        press(4'd5); press(4'd9);
        chk("v_hour", 32'(set_hour), 32'h23);
        chk("v_min", 32'(set_minute), 32'h59);
        chk("v_load", 32'(time_load), 32'h1);

        // Alarm 1 = 06:30, C inside edit ignored.
        press(4'd12);
        chk("sel1", 32'(alarm_sel), 32'h1);
        press(4'd11);
        chk("b_mode", 32'(mode), 32'h2);
        press(4'd0); press(4'd12);
        chk("c_edit_sel", 32'(alarm_sel), 32'h1);
        chk("c_edit_idx", 32'(digit_idx), 32'h1);
        press(4'd6); press(4'd3);
        chk("al_hold", 32'(alarm_hour), 32'h0000);
        press(4'd0);
        chk("al_hour", 32'(alarm_hour), 32'h0600);
        chk("al_min", 32'(alarm_minute), 32'h3001);
        chk("al_en", 32'(alarm_en), 32'h2);
        chk("al_mode", 32'(mode), 32'h0);
        chk("al_tload", 32'(time_load), 32'h0);
        press(4'd12);
        chk("sel_wrap", 32'(alarm_sel), 32'h0);

        // Cancel, then enable toggles.
        press(4'd10); press(4'd1); press(4'd5); press(4'd14);
        chk("cx_mode", 32'(mode), 32'h0);
        chk("cx_hour", 32'(set_hour), 32'h23);
        chk("cx_min", 32'(set_minute), 32'h59);
        chk("cx_load", 32'(time_load), 32'h0);
        chk("cx_idx", 32'(digit_idx), 32'h0);
        press(4'd13);
        chk("d_on", 32'(alarm_en), 32'h3);
        press(4'd13);
        chk("d_off", 32'(alarm_en), 32'h2);
        press(4'd7);
        chk("idle_dig_err", 32'(key_err), 32'h0);
        chk("idle_dig_idx", 32'(digit_idx), 32'h0);

        // Timeout: 8 idle cycles abort.
        press(4'd10); press(4'd1);
        idle(7);
        chk("to7_mode", 32'(mode), 32'h1);
        idle(1);
        chk("to8_mode", 32'(mode), 32'h0);
        chk("to8_hour", 32'(set_hour), 32'h23);
        chk("to8_idx", 32'(digit_idx), 32'h0);
        // Key in the expiring cycle keeps the edit alive.
        press(4'd10); press(4'd1);
        idle(7);
        press(4'd3);
        chk("tk_mode", 32'(mode), 32'h1);
        chk("tk_idx", 32'(digit_idx), 32'h2);
        idle(7);
        chk("tk7_mode", 32'(mode), 32'h1);
        press(4'd14);

        // Asynchronous reset mid-edit.
        press(4'd10); press(4'd1); press(4'd2);
        chk("pre_rst_idx", 32'(digit_idx), 32'h2);
        #2;
        rstn = 1'b0;
        #1;
        chk_reset("arst");
        #3;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        press(4'd5);
        chk("post_mode", 32'(mode), 32'h0);
        chk("post_idx", 32'(digit_idx), 32'h0);
        chk("post_err", 32'(key_err), 32'h0);
        chk("post_hour", 32'(set_hour), 32'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/clock_time_setter.md
# clock_time_setter

Keypad-driven setting controller for the clock: captures BCD time and `NUM_ALARMS` alarm times from decoded key presses, validates each digit against 24-hour limits, and supports cancel, an idle timeout and per-alarm enables. It sits between the keypad decoder and the timekeeping and alarm-compare logic. It is the parametrised successor of the single-alarm status machine.

## Interface
- `NUM_ALARMS`, 2: number of alarm slots, legal range 1..16.
- `TIMEOUT_CYCLES`, 50_000_000: idle cycles in an edit mode before auto-abort; must be ≥ 2.
- `clk` in 1: system clock.
- `rstn` in 1: asynchronous, active-low reset.
- `key_valid` in 1: one-cycle strobe per key press.
- `key_code` in 4: codes 0–9 are digits. 10 (A) = edit time. 11 (B) = edit selected alarm. 12 (C) = next alarm. 13 (D) = toggle selected alarm enable. 14 (\*) = cancel. 15 (#) = ignored.
- `set_hour` out 8: committed time hour, BCD.
- `set_minute` out 8: committed time minute, BCD.
- `time_load` out 1: one-cycle pulse when a new time is committed.
- `alarm_hour` out 8\*NUM_ALARMS: alarm k occupies bits [8k+7:8k], BCD.
- `alarm_minute` out 8\*NUM_ALARMS: same packing as `alarm_hour`.
- `alarm_en` out NUM_ALARMS: per-alarm enable.
- `alarm_sel` out 4: currently selected alarm index.
- `mode` out 2: 0 = IDLE, 1 = EDIT_TIME, 2 = EDIT_ALARM.
- `digit_idx` out 2: next digit to enter in edit mode (0 = hour tens … 3 = minute units). Forced to 0 in IDLE.
- `key_err` out 1: one-cycle pulse when a digit is rejected.

## Operation
- Reset values:
  - `set_hour`/`set_minute` = 0x00.
  - `time_load` and `key_err` = 0.
  - Alarm 0 = 00:01. All other alarms = 00:00.
  - `alarm_en` = 0. `alarm_sel` = 0. `mode` = 0. `digit_idx` = 0.
  - Staging buffer and timeout counter cleared.
- IDLE:
  - A → EDIT_TIME with `digit_idx` = 0.
  - B → EDIT_ALARM (target = `alarm_sel`) with `digit_idx` = 0.
  - C → `alarm_sel` increments; NUM_ALARMS−1 wraps to 0.
  - D → `alarm_en[alarm_sel]` inverts.
  - Digits, \* and # are ignored, with no `key_err`.
- Edit modes:
  - Accepted digits fill a 4-nibble staging buffer at `digit_idx`, then `digit_idx` increments.
  - Committed outputs do not change until the fourth digit.
- Digit validation:
  - d0 ≤ 2.
  - d1 ≤ 3 if d0 = 2, otherwise ≤ 9.
  - d2 ≤ 5.
  - d3 ≤ 9.
  - A rejected digit leaves buffer and `digit_idx` unchanged and pulses `key_err`.
- Commit (fourth digit accepted):
  - EDIT_TIME: `set_hour` = {d0,d1}, `set_minute` = {d2,d3}, `time_load` pulses.
  - EDIT_ALARM: target slot written and `alarm_en[target]` set to 1.
  - Return to IDLE in both cases.
- Cancel (\*) in an edit mode: return to IDLE, discard the buffer, leave all committed values unchanged.
- In edit modes, A, B, C, D and # are ignored with no `key_err`. The target slot is latched at entry; C does not change it.
- Timeout:
  - The counter clears on edit entry and on every `key_valid` while in an edit mode.
  - After TIMEOUT_CYCLES consecutive cycles without `key_valid`, abort exactly as for cancel.
  - The counter is held at 0 in IDLE.

## Timing
- `key_valid` is sampled on the `clk` rising edge. All outputs are registered and change at that same edge, so they are visible the following cycle.
- `time_load` is high for exactly one cycle, coincident with the new `set_hour`/`set_minute` values. `key_err` is high for one cycle after the rejecting edge.
- Back-to-back `key_valid` on consecutive cycles: each key is processed, and a full entry can complete in 5 cycles (A plus 4 digits).
- `key_valid` in the same cycle the timeout would expire: the key is processed and the timeout does not fire.
- Assertion of `rstn` mid-edit immediately (asynchronously) forces all reset values, including alarm 0 = 00:01.
- `key_code` is don't-care when `key_valid` = 0.

## Test plan
- Reset, then A,1,2,3,4 → `set_hour` = 0x12 and `set_minute` = 0x34 with a single-cycle `time_load` on the 4th digit edge; `mode` returns to 0.
- A,2,4 → `key_err` pulses on the "4", `digit_idx` stays 1. Then 3,6 → `key_err` on the "6". Then 5,9 → time committed as 23:59.
- With NUM_ALARMS = 2: C, B,0,6,3,0 → `alarm_sel` = 1, alarm 1 = 06:30, `alarm_en` = 2'b10, alarm 0 still 00:01. C again → `alarm_sel` wraps to 0.
- A,1,5,\* → IDLE, `set_hour`/`set_minute` unchanged, no `time_load`. D → `alarm_en[0]` toggles to 1. D again → back to 0.
- With TIMEOUT_CYCLES = 8: A,1 then 8 idle cycles → `mode` = 0 and no commit. Repeat with a digit at idle cycle 7 → still in EDIT_TIME with `digit_idx` = 2.
- Assert `rstn` low after A,1,2 → all outputs return to reset values asynchronously. After release, a digit key in IDLE has no effect.
